// File: rtl/mvm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mvm_pkg
// Purpose  : Shared types and constants for the matrix-vector multiply block.
// Revision : 1.0
// ============================================================================
package mvm_pkg;

    localparam int LINE_W         = 64;
    localparam int DEFAULT_DATA_W = 8;
    localparam int RESULT_W       = DEFAULT_DATA_W * 3;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CLEAR     = 3'd1,
        REQ       = 3'd2,
        WAIT_DATA = 3'd3,
        LAUNCH    = 3'd4,
        COMPUTE   = 3'd5
    } seq_state_t;

    // Active-low seven-segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] HEX_BLANK = 7'b111_1111;

    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'b100_0000;
            4'h1: seg = 7'b111_1001;
            4'h2: seg = 7'b010_0100;
            4'h3: seg = 7'b011_0000;
            4'h4: seg = 7'b001_1001;
            4'h5: seg = 7'b001_0010;
            4'h6: seg = 7'b000_0010;
            4'h7: seg = 7'b111_1000;
            4'h8: seg = 7'b000_0000;
            4'h9: seg = 7'b001_0000;
            4'hA: seg = 7'b000_1000;
            4'hB: seg = 7'b000_0011;
            4'hC: seg = 7'b100_0110;
            4'hD: seg = 7'b010_0001;
            4'hE: seg = 7'b000_0110;
            default: seg = 7'b000_1110;
        endcase
        return seg;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mvm_load_sequencer_avmm_read_port.sv
`default_nettype none
// ============================================================================
// Module   : avmm_read_port
// Purpose  : Single-outstanding Avalon-MM read handshake with data timeout.
// Revision : 1.0
// ============================================================================
module avmm_read_port #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_en,
    input  logic              wait_en,
    input  logic [ADDR_W-1:0] addr,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    input  logic              mem_waitrequest,
    input  logic              mem_readdatavalid,
    output logic              accepted,
    output logic              beat_valid,
    output logic              timeout
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] wait_cnt;

    // Request and address are held for as long as the FSM sits in REQ.
    assign mem_read    = req_en;
    assign mem_address = req_en ? addr : '0;
    assign accepted    = req_en && !mem_waitrequest;
    assign beat_valid  = wait_en && mem_readdatavalid;
    assign timeout     = wait_en && !mem_readdatavalid && (wait_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (accepted) begin
            wait_cnt <= '0;
        end else if (wait_en && !mem_readdatavalid && !timeout) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/mvm_load_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mvm_load_sequencer
// Purpose  : Fetches DEPTH rows and one vector line, then runs one multiply.
// Revision : 1.0
// ============================================================================
module mvm_load_sequencer
    import mvm_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_W     = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [ADDR_W-1:0]             base_addr,
    output logic                          busy,
    output logic                          done,
    output logic                          error,
    output logic                          result_valid,
    output logic [ADDR_W-1:0]             mem_address,
    output logic                          mem_read,
    input  logic [LINE_W-1:0]             mem_readdata,
    input  logic                          mem_readdatavalid,
    input  logic                          mem_waitrequest,
    output logic                          mac_clr,
    output logic [DEPTH-1:0]              a_wren,
    output logic                          b_wren,
    output logic [LINE_W-1:0]             fifo_data,
    output logic                          mac_start,
    input  logic                          mac_done,
    input  logic [DEPTH*DATA_WIDTH*3-1:0] result_in,
    output logic [DEPTH*DATA_WIDTH*3-1:0] result_out
);
    localparam int IDX_W = $clog2(DEPTH + 1);

    seq_state_t       state, state_nxt;
    logic [IDX_W-1:0] idx;
    logic [ADDR_W-1:0] base;
    logic             wr_phase;
    logic             last_line;
    logic             req_en, wait_en;
    logic             accepted, beat_valid, timeout;

    assign last_line = (idx == IDX_W'(DEPTH));
    assign req_en    = (state == REQ);
    // The write cycle lives inside WAIT_DATA; no new beat is expected then.
    assign wait_en   = (state == WAIT_DATA) && !wr_phase;

    avmm_read_port #(
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT)
    ) u_read_port (
        .clk               (clk),
        .rst               (rst),
        .req_en            (req_en),
        .wait_en           (wait_en),
        .addr              (base + ADDR_W'(idx)),
        .mem_address       (mem_address),
        .mem_read          (mem_read),
        .mem_waitrequest   (mem_waitrequest),
        .mem_readdatavalid (mem_readdatavalid),
        .accepted          (accepted),
        .beat_valid        (beat_valid),
        .timeout           (timeout)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (start) state_nxt = CLEAR;
            CLEAR:     state_nxt = REQ;
            REQ:       if (accepted) state_nxt = WAIT_DATA;
            WAIT_DATA: begin
                if (wr_phase)     state_nxt = last_line ? LAUNCH : REQ;
                else if (timeout) state_nxt = IDLE;
            end
            LAUNCH:    state_nxt = COMPUTE;
            COMPUTE:   if (mac_done) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        mac_clr   = (state == CLEAR);
        mac_start = (state == LAUNCH);
        b_wren    = (state == WAIT_DATA) && wr_phase && last_line;
        a_wren    = '0;
        if ((state == WAIT_DATA) && wr_phase && !last_line) begin
            a_wren = DEPTH'(1) << idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            idx          <= '0;
            base         <= '0;
            wr_phase     <= 1'b0;
            fifo_data    <= '0;
            error        <= 1'b0;
            done         <= 1'b0;
            result_valid <= 1'b0;
            result_out   <= '0;
        end else begin
            state <= state_nxt;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        base         <= base_addr;
                        idx          <= '0;
                        error        <= 1'b0;
                        result_valid <= 1'b0;
                    end
                end
                WAIT_DATA: begin
                    if (wr_phase) begin
                        wr_phase <= 1'b0;
                        idx      <= idx + IDX_W'(1);
                    end else if (beat_valid) begin
                        fifo_data <= mem_readdata;
                        wr_phase  <= 1'b1;
                    end else if (timeout) begin
                        error <= 1'b1;
                    end
                end
                COMPUTE: begin
                    if (mac_done) begin
                        result_out   <= result_in;
                        done         <= 1'b1;
                        result_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mvm_load_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mvm_load_sequencer
// Purpose  : Scoreboard bench with memory responder and stand-in MAC datapath.
// Revision : 1.0
// ============================================================================
module tb_mvm_load_sequencer;
    localparam int DEPTH = 8;
    localparam int DW    = 8;
    localparam int AW    = 32;
    localparam int RW    = DEPTH * DW * 3;

    typedef struct packed {
        logic [3:0]  lane;
        logic [63:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst, start;
    logic [AW-1:0] base_addr;
    logic          busy, done, error, result_valid;
    logic [AW-1:0] mem_address;
    logic          mem_read;
    logic [63:0]   mem_readdata;
    logic          mem_readdatavalid, mem_waitrequest;
    logic          mac_clr;
    logic [DEPTH-1:0] a_wren;
    logic          b_wren;
    logic [63:0]   fifo_data;
    logic          mac_start;
    logic          mac_done;
    logic [RW-1:0] result_in, result_out;

    mvm_load_sequencer #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .ADDR_W(AW), .TIMEOUT(255)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .busy(busy), .done(done), .error(error), .result_valid(result_valid),
        .mem_address(mem_address), .mem_read(mem_read), .mem_readdata(mem_readdata),
        .mem_readdatavalid(mem_readdatavalid), .mem_waitrequest(mem_waitrequest),
        .mac_clr(mac_clr), .a_wren(a_wren), .b_wren(b_wren), .fifo_data(fifo_data),
        .mac_start(mac_start), .mac_done(mac_done), .result_in(result_in),
        .result_out(result_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [AW-1:0]  addr_q[$];
    wr_t            wr_q[$];
    logic [RW-1:0]  res_q[$];

    logic [AW-1:0] cur_base = '0;
    int  n_reads = 0, n_done = 0, n_mstart = 0, n_clr = 0;
    int  lane_cnt[DEPTH+1];
    logic [AW-1:0] stall_addr = '0, stall_hold = '0;
    int  stall_left = 0;
    bit  prev_stalled = 0;
    logic [AW-1:0] drop_addr = '0;
    bit  drop_en = 0;
    bit  stray = 0;
    bit  pend = 0;
    logic [63:0] pend_data = '0;
    logic [63:0] a_rows[DEPTH];
    logic [63:0] b_vec = '0;
    int  dp_cnt = 0;

    // Row r element j = r+1+j; the vector line (offset DEPTH) is all ones.
    function automatic logic [63:0] mem_line(input logic [AW-1:0] off);
        logic [63:0] l;
        for (int j = 0; j < DEPTH; j++)
            l[j*8 +: 8] = (off < AW'(DEPTH)) ? 8'(off + AW'(1) + AW'(j)) : 8'h01;
        return l;
    endfunction

    function automatic logic [RW-1:0] dot_all(input logic [63:0] rows[DEPTH], input logic [63:0] vec);
        logic [RW-1:0] r;
        logic [23:0]   acc;
        logic [7:0]    x, y;
        r = '0;
        for (int i = 0; i < DEPTH; i++) begin
            acc = '0;
            for (int j = 0; j < DEPTH; j++) begin
                x = rows[i][j*8 +: 8];
                y = vec[j*8 +: 8];
                acc = acc + 24'(x) * 24'(y);
            end
            r[i*24 +: 24] = acc;
        end
        return r;
    endfunction

    function automatic logic [RW-1:0] exp_result();
        logic [63:0] rows[DEPTH];
        for (int i = 0; i < DEPTH; i++) rows[i] = mem_line(AW'(i));
        return dot_all(rows, mem_line(AW'(DEPTH)));
    endfunction

    // Memory responder: zero-wait by default, read latency of one cycle.
    initial begin
        mem_waitrequest = 1'b0; mem_readdatavalid = 1'b0; mem_readdata = '0;
        forever begin
            @(negedge clk);
            mem_readdatavalid = pend | stray;
            mem_readdata      = pend ? pend_data : 64'h0BAD_F00D_DEAD_BEEF;
            pend = 0;
            if (prev_stalled && !rst) begin
                checks++;
                if (!mem_read || mem_address !== stall_hold) begin
                    errors++;
                    $display("FAIL stall_hold: got read=%0b addr=%0h expected read=1 addr=%0h",
                             mem_read, mem_address, stall_hold);
                end
            end
            prev_stalled = 0;
            mem_waitrequest = 1'b0;
            if (mem_read) begin
                if (stall_left > 0 && mem_address == stall_addr) begin
                    mem_waitrequest = 1'b1;
                    stall_left--;
                    prev_stalled = 1;
                    stall_hold = mem_address;
                end else begin
                    n_reads++;
                    checks++;
                    if (addr_q.size() == 0) begin
                        errors++;
                        $display("FAIL read_addr: got unexpected read at %0h expected none", mem_address);
                    end else if (mem_address !== addr_q[0]) begin
                        errors++;
                        $display("FAIL read_addr: got %0h expected %0h", mem_address, addr_q[0]);
                        void'(addr_q.pop_front());
                    end else begin
                        void'(addr_q.pop_front());
                    end
                    if (!(drop_en && mem_address == drop_addr)) begin
                        pend = 1;
                        pend_data = mem_line(mem_address - cur_base);
                    end
                end
            end
        end
    end

    // Output monitor and stand-in MAC datapath.
    initial begin
        int  lane;
        wr_t e;
        logic [RW-1:0] er;
        mac_done = 1'b0; result_in = '0;
        forever begin
            @(negedge clk);
            if (a_wren != '0 || b_wren) begin
                checks++;
                if ($countones(a_wren) + int'(b_wren) != 1) begin
                    errors++;
                    $display("FAIL wren_onehot: got a_wren=%b b_wren=%b expected exactly one", a_wren, b_wren);
                end
                lane = DEPTH;
                for (int i = 0; i < DEPTH; i++) if (a_wren[i]) lane = i;
                lane_cnt[lane]++;
                if (lane < DEPTH) a_rows[lane] = fifo_data; else b_vec = fifo_data;
                checks++;
                if (wr_q.size() == 0) begin
                    errors++;
                    $display("FAIL fifo_write: got write lane %0d expected none", lane);
                end else begin
                    e = wr_q.pop_front();
                    if (lane != int'(e.lane) || fifo_data !== e.data) begin
                        errors++;
                        $display("FAIL fifo_write: got lane %0d data %0h expected lane %0d data %0h",
                                 lane, fifo_data, e.lane, e.data);
                    end
                end
            end
            if (mac_clr) n_clr++;
            if (done) begin
                n_done++;
                checks++;
                if (busy !== 1'b0 || result_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL done_flags: got busy=%0b result_valid=%0b expected busy=0 result_valid=1",
                             busy, result_valid);
                end
                checks++;
                if (res_q.size() == 0) begin
                    errors++;
                    $display("FAIL result: got unexpected done expected none");
                end else begin
                    er = res_q.pop_front();
                    if (result_out !== er) begin
                        errors++;
                        $display("FAIL result: got %0h expected %0h", result_out, er);
                    end
                end
            end
            mac_done = 1'b0;
            if (dp_cnt > 0) begin
                dp_cnt--;
                if (dp_cnt == 0) begin
                    result_in = dot_all(a_rows, b_vec);
                    mac_done  = 1'b1;
                end
            end
            if (mac_start) begin
                n_mstart++;
                dp_cnt = 4;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    task automatic launch(input logic [AW-1:0] b);
        cur_base = b;
        for (int i = 0; i <= DEPTH; i++) lane_cnt[i] = 0;
        for (int k = 0; k <= DEPTH; k++) begin
            addr_q.push_back(b + AW'(k));
            wr_q.push_back('{lane: 4'(k), data: mem_line(AW'(k))});
        end
        res_q.push_back(exp_result());
        base_addr = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok, output int cyc);
        ok = 0;
        cyc = budget;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (!busy) begin ok = 1; cyc = c + 1; break; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; base_addr = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, error, result_valid, mem_read, mac_clr, b_wren, mac_start} !== 8'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 00000000",
                     {busy, done, error, result_valid, mem_read, mac_clr, b_wren, mac_start});
        end
        checks++;
        if (mem_address !== '0 || a_wren !== '0 || fifo_data !== '0 || result_out !== '0) begin
            errors++;
            $display("FAIL reset_data: got addr=%0h a_wren=%0h fifo=%0h result=%0h expected all 0",
                     mem_address, a_wren, fifo_data, result_out);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_start: got busy=%0b expected 0", busy);
        end
    endtask

    task automatic test_basic();
        int r0, d0, c0, cyc;
        bit ok;
        r0 = n_reads; d0 = n_done; c0 = n_clr;
        launch(32'h0);
        wait_idle(200, ok, cyc);
        @(negedge clk);
        checks++;
        if (!ok) begin errors++; $display("FAIL basic_finish: got busy after %0d cycles expected idle", cyc); end
        checks++;
        if (n_reads - r0 != 9 || n_done - d0 != 1 || n_clr - c0 != 1) begin
            errors++;
            $display("FAIL basic_counts: got reads=%0d done=%0d clr=%0d expected 9 1 1",
                     n_reads - r0, n_done - d0, n_clr - c0);
        end
        for (int i = 0; i <= DEPTH; i++) begin
            checks++;
            if (lane_cnt[i] != 1) begin
                errors++;
                $display("FAIL basic_lane_writes: got %0d writes on lane %0d expected 1", lane_cnt[i], i);
            end
        end
        checks++;
        if (addr_q.size() != 0 || wr_q.size() != 0 || res_q.size() != 0 || result_valid !== 1'b1) begin
            errors++;
            $display("FAIL basic_drain: got q=%0d/%0d/%0d result_valid=%0b expected 0/0/0 1",
                     addr_q.size(), wr_q.size(), res_q.size(), result_valid);
        end
    endtask

    task automatic test_waitrequest();
        int r0, d0, cyc;
        bit ok;
        r0 = n_reads; d0 = n_done;
        stall_addr = 32'h4; stall_left = 3;
        launch(32'h0);
        wait_idle(200, ok, cyc);
        @(negedge clk);
        checks++;
        if (!ok || stall_left != 0) begin
            errors++;
            $display("FAIL wait_finish: got ok=%0b stalls_left=%0d expected 1 0", ok, stall_left);
        end
        checks++;
        if (n_reads - r0 != 9 || n_done - d0 != 1 || lane_cnt[4] != 1) begin
            errors++;
            $display("FAIL wait_counts: got reads=%0d done=%0d lane4=%0d expected 9 1 1",
                     n_reads - r0, n_done - d0, lane_cnt[4]);
        end
    endtask

    task automatic test_start_while_busy();
        int r0, d0, c0, cyc, n;
        bit ok;
        r0 = n_reads; d0 = n_done; c0 = n_clr;
        launch(32'h10);
        n = 0;
        while (a_wren != 8'h08 && n < 100) begin @(negedge clk); n++; end
        base_addr = 32'h80;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle(200, ok, cyc);
        @(negedge clk);
        checks++;
        if (!ok || n_reads - r0 != 9 || n_done - d0 != 1 || n_clr - c0 != 1) begin
            errors++;
            $display("FAIL busy_start: got ok=%0b reads=%0d done=%0d clr=%0d expected 1 9 1 1",
                     ok, n_reads - r0, n_done - d0, n_clr - c0);
        end
    endtask

    task automatic test_timeout();
        int m0, d0, cyc;
        bit ok;
        m0 = n_mstart; d0 = n_done;
        drop_addr = 32'h2; drop_en = 1;
        launch(32'h0);
        wait_idle(400, ok, cyc);
        @(negedge clk);
        checks++;
        if (!ok || error !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_flag: got ok=%0b error=%0b busy=%0b expected 1 1 0", ok, error, busy);
        end
        checks++;
        if (cyc < 255 || cyc > 280) begin
            errors++;
            $display("FAIL timeout_len: got %0d cycles expected 255..280", cyc);
        end
        checks++;
        if (n_mstart != m0 || n_done != d0) begin
            errors++;
            $display("FAIL timeout_no_launch: got mac_start=%0d done=%0d expected 0 0",
                     n_mstart - m0, n_done - d0);
        end
        addr_q.delete(); wr_q.delete(); res_q.delete();
        drop_en = 0;
        d0 = n_done;
        launch(32'h0);
        checks++;
        if (error !== 1'b0) begin
            errors++;
            $display("FAIL error_clear: got %0b expected 0", error);
        end
        wait_idle(200, ok, cyc);
        @(negedge clk);
        checks++;
        if (!ok || n_done - d0 != 1 || error !== 1'b0) begin
            errors++;
            $display("FAIL timeout_recover: got ok=%0b done=%0d error=%0b expected 1 1 0",
                     ok, n_done - d0, error);
        end
    endtask

    task automatic test_wrap();
        int r0, d0, cyc;
        bit ok;
        r0 = n_reads; d0 = n_done;
        launch(32'hFFFF_FFFC);
        wait_idle(200, ok, cyc);
        @(negedge clk);
        checks++;
        if (!ok || n_reads - r0 != 9 || n_done - d0 != 1 || addr_q.size() != 0) begin
            errors++;
            $display("FAIL wrap: got ok=%0b reads=%0d done=%0d left=%0d expected 1 9 1 0",
                     ok, n_reads - r0, n_done - d0, addr_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int m0, d0, n;
        m0 = n_mstart; d0 = n_done;
        launch(32'h20);
        n = 0;
        while (n_mstart == m0 && n < 200) begin @(negedge clk); n++; end
        checks++;
        if (n_mstart == m0) begin errors++; $display("FAIL rst_mid_launch: got no mac_start expected one"); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        stray = 1;
        @(negedge clk);
        stray = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++;
            if ({busy, done, error, result_valid, mem_read, mac_clr, b_wren, mac_start} !== 8'b0 ||
                a_wren !== '0 || fifo_data !== '0 || result_out !== '0) begin
                errors++;
                $display("FAIL rst_mid_outputs: got flags=%b a_wren=%0h fifo=%0h result=%0h expected all 0",
                         {busy, done, error, result_valid, mem_read, mac_clr, b_wren, mac_start},
                         a_wren, fifo_data, result_out);
            end
        end
        checks++;
        if (n_done != d0) begin
            errors++;
            $display("FAIL rst_mid_done: got %0d done pulses expected 0", n_done - d0);
        end
        addr_q.delete(); wr_q.delete(); res_q.delete();
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) a_rows[i] = '0;
        test_reset();
        test_basic();
        test_waitrequest();
        test_start_while_busy();
        test_timeout();
        test_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
